// File: rtl/ctrl_pkg.sv
// Shared definitions for the multicycle datapath main controller: state codes, opcodes, ALU op codes.
// Latency: n/a (constants and types only).
// Backpressure: n/a.
package ctrl_pkg;

    // State codes are visible on the debug port, so the encoding is fixed.
    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_EXEC   = 4'd6,
        S_ALUWB  = 4'd7,
        S_BEQ    = 4'd8,
        S_ADDIEX = 4'd9,
        S_ADDIWB = 4'd10,
        S_JUMP   = 4'd11,
        S_BNE    = 4'd12
    } state_t;

    // Opcode field values (instr[31:26]).
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    // Codes handed to the ALU decoder.
    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_BEQ   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;
    localparam logic [1:0] ALUOP_BNE   = 2'b11;

    // ALU B operand selects.
    localparam logic [1:0] SRCB_REG  = 2'b00;
    localparam logic [1:0] SRCB_FOUR = 2'b01;
    localparam logic [1:0] SRCB_IMM  = 2'b10;
    localparam logic [1:0] SRCB_IMM4 = 2'b11;

    // PC source selects.
    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

endpackage

// File: rtl/main_control_fsm.sv
// Main control FSM of the 32-bit multicycle datapath (Moore; pcEn also depends on zero in branch states).
// Latency: lw 5 cycles; sw, R-type, addi 4; beq, bne, j 3 (FETCH included); outputs combinational from state.
// Backpressure: none; advances every clock, synchronous active-high reset forces FETCH.
//
// Ports:
//   clk, reset         clock and synchronous active-high reset
//   op[5:0]            opcode from instruction register, sampled in DECODE and MEMADR only
//   zero               ALU zero flag, used in BEQ/BNE
//   state[3:0]         current state code (debug)
//   pcEn .. pcSrc      datapath control strobes and mux selects
module main_control_fsm
    import ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] op,
    input  logic       zero,
    output logic [3:0] state,
    output logic       pcEn,
    output logic       irWrite,
    output logic       memWrite,
    output logic       regWrite,
    output logic       iorD,
    output logic       regDst,
    output logic       memToReg,
    output logic       aluSrcA,
    output logic [1:0] aluSrcB,
    output logic [1:0] aluOp,
    output logic [1:0] pcSrc
);

    state_t cur_st;
    state_t nxt_st;

    always_ff @(posedge clk) begin
        if (reset) begin
            cur_st <= S_FETCH;
        end else begin
            cur_st <= nxt_st;
        end
    end

    assign state = cur_st;

    // Next-state logic. Unknown opcodes in DECODE fall back to FETCH so the
    // instruction retires with nothing but the FETCH PC increment.
    always_comb begin
        nxt_st = S_FETCH;
        case (cur_st)
            S_FETCH:  nxt_st = S_DECODE;
            S_DECODE: begin
                case (op)
                    OP_LW, OP_SW: nxt_st = S_MEMADR;
                    OP_RTYPE:     nxt_st = S_EXEC;
                    OP_BEQ:       nxt_st = S_BEQ;
                    OP_BNE:       nxt_st = S_BNE;
                    OP_ADDI:      nxt_st = S_ADDIEX;
                    OP_J:         nxt_st = S_JUMP;
                    default:      nxt_st = S_FETCH;
                endcase
            end
            S_MEMADR: nxt_st = (op == OP_LW) ? S_MEMRD : S_MEMWR;
            S_MEMRD:  nxt_st = S_MEMWB;
            S_EXEC:   nxt_st = S_ALUWB;
            S_ADDIEX: nxt_st = S_ADDIWB;
            default:  nxt_st = S_FETCH;
        endcase
    end

    // Output decode. Every output idles at 0; each state raises only what it needs.
    always_comb begin
        pcEn     = 1'b0;
        irWrite  = 1'b0;
        memWrite = 1'b0;
        regWrite = 1'b0;
        iorD     = 1'b0;
        regDst   = 1'b0;
        memToReg = 1'b0;
        aluSrcA  = 1'b0;
        aluSrcB  = SRCB_REG;
        aluOp    = ALUOP_ADD;
        pcSrc    = PCSRC_ALU;
        case (cur_st)
            S_FETCH: begin
                irWrite = 1'b1;
                pcEn    = 1'b1;
                aluSrcB = SRCB_FOUR;
            end
            S_DECODE: begin
                // Branch target precomputed into ALUOut while decoding.
                aluSrcB = SRCB_IMM4;
            end
            S_MEMADR, S_ADDIEX: begin
                aluSrcA = 1'b1;
                aluSrcB = SRCB_IMM;
            end
            S_MEMRD: begin
                iorD = 1'b1;
            end
            S_MEMWR: begin
                iorD     = 1'b1;
                memWrite = 1'b1;
            end
            S_MEMWB: begin
                regWrite = 1'b1;
                memToReg = 1'b1;
            end
            S_EXEC: begin
                aluSrcA = 1'b1;
                aluOp   = ALUOP_FUNCT;
            end
            S_ALUWB: begin
                regWrite = 1'b1;
                regDst   = 1'b1;
            end
            S_ADDIWB: begin
                regWrite = 1'b1;
            end
            S_BEQ: begin
                aluSrcA = 1'b1;
                aluOp   = ALUOP_BEQ;
                pcSrc   = PCSRC_ALUOUT;
                pcEn    = zero;
            end
            S_BNE: begin
                aluSrcA = 1'b1;
                aluOp   = ALUOP_BNE;
                pcSrc   = PCSRC_ALUOUT;
                pcEn    = ~zero;
            end
            S_JUMP: begin
                pcSrc = PCSRC_JUMP;
                pcEn  = 1'b1;
            end
            default: begin
                // Unused codes keep every output at its idle value.
            end
        endcase
    end

endmodule
